reg_file_param: RTL and testbench

REG_FILE_PARAM -- requirements
Module: reg_file_param

---
 rtl/reg_file_param_pkg.sv | 13 +
 rtl/reg_clear_seq.sv | 58 +++++
 rtl/reg_file_param.sv | 87 ++++++++
 tb/tb_reg_file_param.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_param_pkg.sv
// Shared types and default sizes for the parameterised register file and
// its clear sequencer.
package reg_file_param_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clr_state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;

endpackage

// File: rtl/reg_clear_seq.sv
// Sweep-clear sequencer: on a CLEAR request, walks every register address
// once, producing a clear enable and address, and reports BUSY meanwhile.
module reg_clear_seq
  import reg_file_param_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  output logic              o_busy,
  output logic              o_clr_en,
  output logic [ADDR_W-1:0] o_clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  clr_state_t        r_state;
  clr_state_t        w_state_next;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // CLEAR is only sampled in IDLE, so a request during a sweep never restarts it.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (i_clear) begin
          w_state_next = SWEEP;
          w_cnt_next   = '0;
        end
      end
      SWEEP: begin
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == LAST_ADDR) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign o_busy     = (r_state == SWEEP);
  assign o_clr_en   = (r_state == SWEEP);
  assign o_clr_addr = r_cnt;

endmodule

// File: rtl/reg_file_param.sv
// Parameterised register file: one write port, two combinational read ports,
// optional hard-wired zero register, optional write-to-read bypass, sweep clear.
module reg_file_param
  import reg_file_param_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_in,
  input  logic [ADDR_W-1:0] i_in_address,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_out1_address,
  input  logic [ADDR_W-1:0] i_out2_address,
  output logic [DATA_W-1:0] o_out1,
  output logic [DATA_W-1:0] o_out2,
  input  logic              i_clear,
  output logic              o_busy,
  output logic              o_write_dropped
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_write_dropped;
  logic              w_busy;
  logic              w_clr_en;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_zero_target;
  logic              w_wr_legal;
  logic [ADDR_W-1:0] w_raddr [2];

  reg_clear_seq #(
    .ADDR_W(ADDR_W)
  ) u_clear_seq (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (i_clear),
    .o_busy     (w_busy),
    .o_clr_en   (w_clr_en),
    .o_clr_addr (w_clr_addr)
  );

  // Writes to a hard-wired zero register vanish silently rather than counting as refused.
  assign w_zero_target = (ZERO_REG != 0) && (i_in_address == '0);
  assign w_wr_legal    = i_write && !w_busy && !w_zero_target;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_write_dropped <= 1'b0;
    end else begin
      if (w_clr_en) begin
        r_mem[w_clr_addr] <= '0;
      end else if (w_wr_legal) begin
        r_mem[i_in_address] <= i_in;
      end
      r_write_dropped <= i_write && w_busy;
    end
  end

  assign w_raddr[0] = i_out1_address;
  assign w_raddr[1] = i_out2_address;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [DATA_W-1:0] w_rd;
    always_comb begin
      w_rd = r_mem[w_raddr[gi]];
      if ((ZERO_REG != 0) && (w_raddr[gi] == '0)) begin
        w_rd = '0;
      end else if ((BYPASS != 0) && w_wr_legal && (w_raddr[gi] == i_in_address)) begin
        w_rd = i_in;
      end
    end
  end

  assign o_out1          = g_rd[0].w_rd;
  assign o_out2          = g_rd[1].w_rd;
  assign o_busy          = w_busy;
  assign o_write_dropped = r_write_dropped;

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: three parameterisations driven in lockstep,
// table vectors, directed sweep/reset sequences and a random run.
module tb_reg_file_param;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic [2:0] waddr;
  logic       write;
  logic [2:0] a1;
  logic [2:0] a2;
  logic       clear;

  logic [7:0] out1 [3];
  logic [7:0] out2 [3];
  logic       busy [3];
  logic       drop [3];

  int n_checks = 0;
  int n_errors = 0;

  // Configurations: 0 = defaults, 1 = no bypass, 2 = zero register with bypass
  bit cfg_zr  [3] = '{1'b0, 1'b0, 1'b1};
  bit cfg_byp [3] = '{1'b1, 1'b0, 1'b1};

  // Reference model: register contents, sweep position (-1 when idle)
  int m_mem [3][8];
  int m_pos;
  int m_drop;

  // Values sampled just before the most recent edge
  int s_out1 [3];
  int s_out2 [3];
  int s_busy [3];
  int s_drop [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in(din), .i_in_address(waddr), .i_write(write),
    .i_out1_address(a1), .i_out2_address(a2), .o_out1(out1[0]), .o_out2(out2[0]),
    .i_clear(clear), .o_busy(busy[0]), .o_write_dropped(drop[0]));

  reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in(din), .i_in_address(waddr), .i_write(write),
    .i_out1_address(a1), .i_out2_address(a2), .o_out1(out1[1]), .o_out2(out2[1]),
    .i_clear(clear), .o_busy(busy[1]), .o_write_dropped(drop[1]));

  reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in(din), .i_in_address(waddr), .i_write(write),
    .i_out1_address(a1), .i_out2_address(a2), .o_out1(out1[2]), .o_out2(out2[2]),
    .i_clear(clear), .o_busy(busy[2]), .o_write_dropped(drop[2]));

  typedef struct {
    int w; int wa; int d; int ra1; int ra2; int clr;
    int e_out1; int e_out2; int e_busy; int e_drop;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic int exp_read(input int c, input int a);
    if (cfg_zr[c] && a == 0) return 0;
    if (cfg_byp[c] && write && m_pos < 0 && int'(waddr) == a) return int'(din);
    return m_mem[c][a];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++)
      for (int a = 0; a < 8; a++) m_mem[c][a] = 0;
    m_pos  = -1;
    m_drop = 0;
  endtask

  // One clock transaction: apply inputs, check all DUTs against the model, take the edge.
  task automatic cyc(input int w, input int wa, input int d, input int ra1, input int ra2, input int clr);
    @(negedge clk);
    write = w[0]; waddr = wa[2:0]; din = d[7:0]; a1 = ra1[2:0]; a2 = ra2[2:0]; clear = clr[0];
    #1;
    for (int c = 0; c < 3; c++) begin
      s_out1[c] = int'(out1[c]); s_out2[c] = int'(out2[c]);
      s_busy[c] = int'(busy[c]); s_drop[c] = int'(drop[c]);
      chk($sformatf("busy[%0d]", c), s_busy[c], (m_pos >= 0) ? 1 : 0);
      chk($sformatf("write_dropped[%0d]", c), s_drop[c], m_drop);
      chk($sformatf("out1[%0d]@%0d", c, ra1), s_out1[c], exp_read(c, ra1));
      chk($sformatf("out2[%0d]@%0d", c, ra2), s_out2[c], exp_read(c, ra2));
    end
    $display("cyc w=%0d wa=%0d d=%0d a1=%0d a2=%0d clr=%0d -> out1=%0d out2=%0d busy=%0d drop=%0d",
             w, wa, d, ra1, ra2, clr, s_out1[0], s_out2[0], s_busy[0], s_drop[0]);
    @(posedge clk);
    if (m_pos >= 0) begin
      for (int c = 0; c < 3; c++) m_mem[c][m_pos] = 0;
      m_drop = w;
      m_pos++;
      if (m_pos == 8) m_pos = -1;
    end else begin
      m_drop = 0;
      if (w != 0)
        for (int c = 0; c < 3; c++)
          if (!(cfg_zr[c] && wa == 0)) m_mem[c][wa] = d & 8'hFF;
      if (clr != 0) m_pos = 0;
    end
  endtask

  initial begin
    int busy_cnt;
    bit seen_busy;

    // w  wa d   a1 a2 clr | out1 out2 busy drop  (defaults configuration)
    vecs[0]  = '{0, 0, 0,  2, 0, 0,   0,  0, 0, 0};
    vecs[1]  = '{1, 2, 95, 2, 3, 0,  95,  0, 0, 0};
    vecs[2]  = '{0, 0, 0,  2, 5, 0,  95,  0, 0, 0};
    vecs[3]  = '{1, 1, 28, 2, 1, 0,  95, 28, 0, 0};
    vecs[4]  = '{0, 0, 0,  1, 2, 0,  28, 95, 0, 0};
    vecs[5]  = '{1, 7, 7,  7, 0, 0,   7,  0, 0, 0};
    vecs[6]  = '{0, 0, 0,  7, 1, 1,   7, 28, 0, 0};
    vecs[7]  = '{1, 5, 50, 5, 1, 0,   0, 28, 1, 0};
    vecs[8]  = '{0, 0, 0,  1, 7, 0,  28,  7, 1, 1};
    vecs[9]  = '{0, 0, 0,  1, 2, 0,   0, 95, 1, 0};
    vecs[10] = '{0, 0, 0,  2, 7, 0,   0,  7, 1, 0};
    vecs[11] = '{0, 0, 0,  7, 5, 0,   7,  0, 1, 0};
    vecs[12] = '{0, 0, 0,  7, 0, 1,   7,  0, 1, 0};
    vecs[13] = '{0, 0, 0,  7, 5, 0,   7,  0, 1, 0};
    vecs[14] = '{0, 0, 0,  7, 2, 0,   7,  0, 1, 0};
    vecs[15] = '{0, 0, 0,  7, 2, 0,   0,  0, 0, 0};

    rst_n = 1'b0; write = 1'b0; waddr = '0; din = '0; a1 = 3'd2; a2 = 3'd5; clear = 1'b0;
    model_reset();
    #12;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("reset busy[%0d]", c), int'(busy[c]), 0);
      chk($sformatf("reset drop[%0d]", c), int'(drop[c]), 0);
      chk($sformatf("reset out1[%0d]", c), int'(out1[c]), 0);
      chk($sformatf("reset out2[%0d]", c), int'(out2[c]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors
    for (int i = 0; i < 16; i++) begin
      cyc(vecs[i].w, vecs[i].wa, vecs[i].d, vecs[i].ra1, vecs[i].ra2, vecs[i].clr);
      chk($sformatf("vec%0d out1", i), s_out1[0], vecs[i].e_out1);
      chk($sformatf("vec%0d out2", i), s_out2[0], vecs[i].e_out2);
      chk($sformatf("vec%0d busy", i), s_busy[0], vecs[i].e_busy);
      chk($sformatf("vec%0d drop", i), s_drop[0], vecs[i].e_drop);
    end

    // Zero register: write 6 to r0 is swallowed without a drop flag
    cyc(1, 0, 6, 0, 0, 0);
    chk("zr out1 same cycle", s_out1[2], 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("zr out1 after edge", s_out1[2], 0);
    chk("zr no drop", s_drop[2], 0);
    chk("nozr r0 written", s_out1[0], 6);

    // Fill 1..8, clear, count BUSY cycles and watch r3
    for (int i = 0; i < 8; i++) cyc(1, i, i + 1, i, 3, 0);
    cyc(0, 0, 0, 3, 0, 1);
    busy_cnt = 0;
    seen_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 3, 7, 0);
      chk($sformatf("sweep r3 step%0d", i), s_out1[0], (i <= 3) ? 4 : 0);
      if (s_busy[0] != 0) begin
        busy_cnt++;
        seen_busy = 1'b1;
      end else if (seen_busy) begin
        break;
      end
    end
    chk("busy cycle count", busy_cnt, 8);

    // CLEAR held through a whole sweep restarts on the first idle edge
    for (int i = 0; i < 12; i++) cyc(1, i % 8, 3 * i + 1, i % 8, (i + 3) % 8, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, i % 8, 0, 0);

    // Reset during sweep cycle 3 aborts the sweep immediately
    for (int i = 0; i < 8; i++) cyc(1, i, 10 + i, i, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 5, 6, 0);
    @(negedge clk);
    write = 1'b0; clear = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int c = 0; c < 3; c++) chk($sformatf("abort busy[%0d]", c), int'(busy[c]), 0);
    for (int a = 0; a < 8; a++) begin
      a1 = a[2:0];
      a2 = 3'(7 - a);
      #1;
      chk($sformatf("abort out1@%0d", a), int'(out1[0]), 0);
      chk($sformatf("abort out2@%0d", 7 - a), int'(out2[1]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 4, 15, 0, 1, 0);
    cyc(0, 0, 0, 4, 5, 0);
    chk("post-reset r4", s_out1[1], 15);

    // Randomised traffic against the model
    for (int i = 0; i < 250; i++) begin
      cyc(($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 255),
          $urandom_range(0, 7), $urandom_range(0, 7), ($urandom_range(0, 19) == 0) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
